// File: rtl/bin2ascii_serializer.sv
// bin2ascii_serializer
//
// Converts a 4-bit binary value (0-15) into a two-digit decimal ASCII string
// and streams it one byte per valid/ready handshake: tens digit, ones digit,
// then an optional newline (0x0A) when TERMINATE is set.
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset    in   1  asynchronous active-high reset
//   in_val   in   1  producer has a value on in_
//   in_rdy   out  1  block is idle and can accept a value
//   in_      in   4  binary value to convert, 0-15
//   out_val  out  1  out_ holds a valid ASCII byte
//   out_rdy  in   1  sink accepts the byte this cycle
//   out_     out  8  ASCII character
//
// All outputs decode from registered state only; nothing combinational runs
// from in_val/out_rdy to any output.
module bin2ascii_serializer #(
  parameter bit TERMINATE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] in_,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [7:0] out_
);

  typedef enum logic [1:0] {
    StIdle,
    StTens,
    StOnes,
    StTerm
  } state_e;

  state_e     state_q;
  logic       tens_q;  // 0-15 only ever has a tens digit of 0 or 1
  logic [3:0] ones_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      tens_q  <= 1'b0;
      ones_q  <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_val) begin
            state_q <= StTens;
            tens_q  <= (in_ >= 4'd10);
            ones_q  <= (in_ >= 4'd10) ? (in_ - 4'd10) : in_;
          end
        end
        StTens: begin
          if (out_rdy) state_q <= StOnes;
        end
        StOnes: begin
          if (out_rdy) state_q <= TERMINATE ? StTerm : StIdle;
        end
        StTerm: begin
          if (out_rdy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_rdy  = (state_q == StIdle);
    out_val = 1'b0;
    out_    = 8'h00;
    unique case (state_q)
      StIdle: begin
        out_val = 1'b0;
        out_    = 8'h00;
      end
      StTens: begin
        out_val = 1'b1;
        out_    = {4'h3, 3'b000, tens_q};
      end
      StOnes: begin
        out_val = 1'b1;
        out_    = {4'h3, ones_q};
      end
      StTerm: begin
        out_val = 1'b1;
        out_    = 8'h0A;
      end
      default: begin
        out_val = 1'b0;
        out_    = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_bin2ascii_serializer.sv
// Bench for bin2ascii_serializer: one instance with the newline terminator,
// one without. Inputs are driven 1 time unit after the rising edge; the
// accepted output bytes are logged on the falling edge.
module tb_bin2ascii_serializer;

  localparam int N = 1000;

  logic       clk;
  logic       reset;
  logic       in_val0, in_rdy0, out_val0, out_rdy0;
  logic [3:0] in0;
  logic [7:0] out0;
  logic       in_val1, in_rdy1, out_val1, out_rdy1;
  logic [3:0] in1;
  logic [7:0] out1;

  bin2ascii_serializer #(.TERMINATE(1'b0)) dut0 (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val0),
    .in_rdy (in_rdy0),
    .in_    (in0),
    .out_val(out_val0),
    .out_rdy(out_rdy0),
    .out_   (out0)
  );

  bin2ascii_serializer #(.TERMINATE(1'b1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val1),
    .in_rdy (in_rdy1),
    .in_    (in1),
    .out_val(out_val1),
    .out_rdy(out_rdy1),
    .out_   (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int xbad    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Byte log: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_val0 && out_rdy0) begin
        if ($isunknown(out0)) xbad++;
        q0.push_back(out0);
      end
      if (out_val1 && out_rdy1) begin
        if ($isunknown(out1)) xbad++;
        q1.push_back(out1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Decoder round trip: two ASCII digits back to a binary value.
  function automatic int dec2(input logic [7:0] a, input logic [7:0] b);
    return (int'(a) - 48) * 10 + (int'(b) - 48);
  endfunction

  // Reference string for one value, straight from the decimal definition.
  task automatic ref_push(input int v, input bit term, inout logic [7:0] q[$]);
    q.push_back(8'(48 + v / 10));
    q.push_back(8'(48 + v % 10));
    if (term) q.push_back(8'h0A);
  endtask

  task automatic cmp_q(input string name, input logic [7:0] act[$], input logic [7:0] exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++) begin
      chk(name, {24'd0, act[i]}, {24'd0, exp[i]});
    end
  endtask

  typedef struct {
    logic [3:0] val;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_q[$];
  logic [7:0] got0;
  logic [3:0] vals0[N];
  logic [3:0] vals1[N];
  int         idx0, idx1;
  logic       seen0, seen1;
  int         tmo;

  initial begin
    vecs[0] = '{val: 4'd5,  b0: 8'h30, b1: 8'h35};
    vecs[1] = '{val: 4'd0,  b0: 8'h30, b1: 8'h30};
    vecs[2] = '{val: 4'd9,  b0: 8'h30, b1: 8'h39};
    vecs[3] = '{val: 4'd10, b0: 8'h31, b1: 8'h30};
    vecs[4] = '{val: 4'd15, b0: 8'h31, b1: 8'h35};

    reset = 1'b1;
    in_val0 = 1'b0; in0 = 4'd0; out_rdy0 = 1'b0;
    in_val1 = 1'b0; in1 = 4'd0; out_rdy1 = 1'b0;

    // Reset state, while held and after release.
    #2;
    chk("rst_in_rdy1", in_rdy1, 1);
    chk("rst_out_val1", out_val1, 0);
    chk("rst_out1", out1, 8'h00);
    chk("rst_in_rdy0", in_rdy0, 1);
    chk("rst_out_val0", out_val0, 0);
    cyc();
    cyc();
    reset = 1'b0;
    chk("rel_in_rdy1", in_rdy1, 1);
    chk("rel_out_val1", out_val1, 0);
    chk("rel_out0", out0, 8'h00);

    // Value 13 with terminator, sink always ready.
    out_rdy0 = 1'b1;
    out_rdy1 = 1'b1;
    in_val1 = 1'b1; in1 = 4'd13;
    cyc();
    in_val1 = 1'b0;
    chk("v13_b0", out1, 8'h31);
    chk("v13_val", out_val1, 1);
    chk("v13_rdy_busy", in_rdy1, 0);
    cyc();
    chk("v13_b1", out1, 8'h33);
    cyc();
    chk("v13_nl", out1, 8'h0A);
    cyc();
    chk("v13_done_rdy", in_rdy1, 1);
    chk("v13_done_val", out_val1, 0);
    chk("v13_done_out", out1, 8'h00);

    // Table sweep without terminator.
    for (int i = 0; i < 5; i++) begin
      chk("tab_idle_rdy", in_rdy0, 1);
      in_val0 = 1'b1; in0 = vecs[i].val;
      cyc();
      in_val0 = 1'b0;
      chk("tab_b0_val", out_val0, 1);
      chk("tab_b0", out0, vecs[i].b0);
      got0 = out0;
      cyc();
      chk("tab_b1", out0, vecs[i].b1);
      chk("tab_roundtrip", dec2(got0, out0), vecs[i].val);
      cyc();
      chk("tab_end_val", out_val0, 0);
      chk("tab_end_rdy", in_rdy0, 1);
    end

    // Backpressure on value 12: 3 stalled cycles in tens, 2 in ones.
    q1.delete();
    out_rdy1 = 1'b0;
    in_val1 = 1'b1; in1 = 4'd12;
    cyc();
    in_val1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_tens_hold", {out_val1, out1}, {1'b1, 8'h31});
      cyc();
    end
    out_rdy1 = 1'b1;
    chk("bp_tens", out1, 8'h31);
    cyc();
    out_rdy1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_ones_hold", {out_val1, out1}, {1'b1, 8'h32});
      cyc();
    end
    out_rdy1 = 1'b1;
    chk("bp_ones", out1, 8'h32);
    cyc();
    chk("bp_nl", out1, 8'h0A);
    cyc();
    chk("bp_idle", in_rdy1, 1);
    exp_q.delete();
    ref_push(12, 1'b1, exp_q);
    cmp_q("bp_stream", q1, exp_q);

    // Input stall: 14 held on in_ while 7 is being emitted.
    q1.delete();
    in_val1 = 1'b1; in1 = 4'd7;
    cyc();
    in1 = 4'd14;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdy_low", in_rdy1, 0);
      cyc();
    end
    chk("stall_rdy_back", in_rdy1, 1);
    cyc();
    in_val1 = 1'b0;
    tmo = 0;
    while (!in_rdy1 && tmo < 20) begin
      cyc();
      tmo++;
    end
    chk("stall_finish", in_rdy1, 1);
    exp_q.delete();
    ref_push(7, 1'b1, exp_q);
    ref_push(14, 1'b1, exp_q);
    cmp_q("stall_stream", q1, exp_q);

    // Asynchronous reset while in the ones state of value 11.
    in_val1 = 1'b1; in1 = 4'd11;
    cyc();
    in_val1 = 1'b0;
    cyc();
    chk("mid_ones", out1, 8'h31);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_val", out_val1, 0);
    chk("mid_rst_rdy", in_rdy1, 1);
    chk("mid_rst_out", out1, 8'h00);
    cyc();
    reset = 1'b0;
    q1.delete();
    in_val1 = 1'b1; in1 = 4'd3;
    cyc();
    in_val1 = 1'b0;
    chk("post_rst_b0", out1, 8'h30);
    cyc();
    cyc();
    cyc();
    chk("post_rst_idle", in_rdy1, 1);
    exp_q.delete();
    ref_push(3, 1'b1, exp_q);
    cmp_q("post_rst_stream", q1, exp_q);

    // Random soak on both instances.
    for (int i = 0; i < N; i++) begin
      vals0[i] = 4'($urandom_range(0, 15));
      vals1[i] = 4'($urandom_range(0, 15));
    end
    q0.delete();
    q1.delete();
    idx0 = 0; idx1 = 0; seen0 = 1'b0; seen1 = 1'b0;
    for (int c = 0; c < 40000 && !(idx0 == N && idx1 == N && !out_val0 && !out_val1); c++) begin
      cyc();
      if (in_val1 && seen1) begin
        in_val1 = 1'b0;
        idx1++;
      end
      if (!in_val1 && idx1 < N && $urandom_range(0, 1) == 1) begin
        in_val1 = 1'b1;
        in1 = vals1[idx1];
      end
      out_rdy1 = ($urandom_range(0, 3) != 0);
      seen1 = in_rdy1;
      if (in_val0 && seen0) begin
        in_val0 = 1'b0;
        idx0++;
      end
      if (!in_val0 && idx0 < N && $urandom_range(0, 1) == 1) begin
        in_val0 = 1'b1;
        in0 = vals0[idx0];
      end
      out_rdy0 = ($urandom_range(0, 3) != 0);
      seen0 = in_rdy0;
    end
    chk("soak_done", {idx1 == N, idx0 == N, out_val1, out_val0}, 4'b1100);
    exp_q.delete();
    for (int i = 0; i < N; i++) ref_push(int'(vals1[i]), 1'b1, exp_q);
    cmp_q("soak_t1", q1, exp_q);
    exp_q.delete();
    for (int i = 0; i < N; i++) ref_push(int'(vals0[i]), 1'b0, exp_q);
    cmp_q("soak_t0", q0, exp_q);
    chk("no_x_out", xbad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
